// File: rtl/dkongjr_pal_pkg.sv
// dkongjr_pal_pkg: shared state encoding and sizes for the palette loader
package dkongjr_pal_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD2E = 3'd1,
    LOAD2F = 3'd2,
    CHECK  = 3'd3,
    DONE   = 3'd4
  } pal_state_t;
  localparam int PAL_AW    = 8;
  localparam int PAL_BYTES = 512;
endpackage

// File: rtl/dkongjr_pal_hold.sv
// dkongjr_pal_hold: one-entry byte hold register with blank-gated drain
module dkongjr_pal_hold #(
  parameter bit WRITE_IN_BLANK = 1'b1
) (
  input  logic       CLK_6M,
  input  logic       W_1EF_RST,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] data,
  input  logic       drain_en,
  input  logic       cmpblk_n,
  output logic       full,
  output logic [7:0] q,
  output logic       drain
);
  // load needs an empty entry and drain a full one, so they never coincide
  assign drain = full && drain_en && (!WRITE_IN_BLANK || !cmpblk_n);
  always_ff @(posedge CLK_6M or negedge W_1EF_RST)
    if (!W_1EF_RST) begin
      full <= 1'b0;
      q    <= 8'h00;
    end else if (clr) full <= 1'b0;
    else if (load) begin
      full <= 1'b1;
      q    <= data;
    end else if (drain) full <= 1'b0;
endmodule

// File: rtl/dkongjr_pal_loader.sv
// dkongjr_pal_loader: sequences a checksummed byte stream into palette RAMs 2E and 2F
module dkongjr_pal_loader
  import dkongjr_pal_pkg::*;
#(
  parameter int PAL_DEPTH      = 256,
  parameter bit WRITE_IN_BLANK = 1'b1
) (
  input  logic              CLK_6M,
  input  logic              W_1EF_RST,
  input  logic              I_START,
  input  logic              I_CMPBLKn,
  input  logic              I_DL_VALID,
  input  logic [7:0]        I_DL_DATA,
  output logic              O_DL_READY,
  output logic [PAL_AW-1:0] O_CNF_A,
  output logic [7:0]        O_CNF_D,
  output logic              O_CNF_EN,
  output logic              O_WE2,
  output logic              O_WE3,
  output logic              O_BUSY,
  output logic              O_DONE,
  output logic              O_ERR
);
  localparam logic [PAL_AW-1:0] LAST = PAL_AW'(PAL_DEPTH - 1);
  pal_state_t        state, state_d;
  logic [PAL_AW-1:0] addr;
  logic [7:0]        csum, hold_q;
  logic              full, wr, busy, err;
  assign busy       = state inside {LOAD2E, LOAD2F, CHECK};
  assign O_CNF_EN   = busy;
  assign O_BUSY     = busy;
  assign O_DL_READY = busy && !full;
  assign O_DONE     = state == DONE;
  assign O_ERR      = err;
  // a held trailer in CHECK is consumed by the move to DONE, never written
  dkongjr_pal_hold #(.WRITE_IN_BLANK(WRITE_IN_BLANK)) u_hold (
    .CLK_6M    (CLK_6M),
    .W_1EF_RST (W_1EF_RST),
    .clr       (I_START || (state == CHECK && full)),
    .load      (I_DL_VALID && O_DL_READY),
    .data      (I_DL_DATA),
    .drain_en  (state == LOAD2E || state == LOAD2F),
    .cmpblk_n  (I_CMPBLKn),
    .full      (full),
    .q         (hold_q),
    .drain     (wr)
  );
  always_ff @(posedge CLK_6M or negedge W_1EF_RST)
    if (!W_1EF_RST) state <= IDLE;
    else state <= state_d;
  always_comb begin
    state_d = state;
    if (I_START) state_d = LOAD2E;
    else if (wr && addr == LAST) state_d = (state == LOAD2E) ? LOAD2F : CHECK;
    else if (state == CHECK && full) state_d = DONE;
  end
  always_ff @(posedge CLK_6M or negedge W_1EF_RST)
    if (!W_1EF_RST) begin
      addr    <= '0;
      csum    <= 8'h00;
      err     <= 1'b0;
      O_CNF_A <= '0;
      O_CNF_D <= 8'h00;
      O_WE2   <= 1'b0;
      O_WE3   <= 1'b0;
    end else if (I_START) begin
      addr  <= '0;
      csum  <= 8'h00;
      err   <= 1'b0;
      O_WE2 <= 1'b0;
      O_WE3 <= 1'b0;
    end else begin
      O_WE2 <= wr && state == LOAD2E;
      O_WE3 <= wr && state == LOAD2F;
      if (wr) begin
        O_CNF_A <= addr;
        O_CNF_D <= hold_q;
        addr    <= addr + 1'b1;
      end
      if (I_DL_VALID && O_DL_READY) csum <= csum + I_DL_DATA;
      if (state == CHECK && full) err <= csum != 8'h00;
    end
endmodule

// File: tb/tb_dkongjr_pal_loader.sv
// tb_dkongjr_pal_loader: directed checks of the palette loader, WRITE_IN_BLANK 0 (u0) and 1 (u1)
module tb_dkongjr_pal_loader;
  import dkongjr_pal_pkg::*;
  logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, blank_n = 1'b0, valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       r0, en0, w2_0, w3_0, b0, dn0, e0;
  logic       r1, en1, w2_1, w3_1, b1, dn1, e1;
  logic [7:0] a0, d0, a1, d1;
  int         n_chk = 0, n_fail = 0, exp_idx = 0, we_cnt, rdy_cnt;
  bit         mon_en = 1'b0;
  logic [7:0] exp_data [PAL_BYTES];

  always #5 clk = ~clk;

  dkongjr_pal_loader #(.PAL_DEPTH(256), .WRITE_IN_BLANK(1'b0)) u0 (
    .CLK_6M(clk), .W_1EF_RST(rst_n), .I_START(start), .I_CMPBLKn(blank_n),
    .I_DL_VALID(valid), .I_DL_DATA(data), .O_DL_READY(r0), .O_CNF_A(a0),
    .O_CNF_D(d0), .O_CNF_EN(en0), .O_WE2(w2_0), .O_WE3(w3_0), .O_BUSY(b0),
    .O_DONE(dn0), .O_ERR(e0)
  );
  dkongjr_pal_loader #(.PAL_DEPTH(256), .WRITE_IN_BLANK(1'b1)) u1 (
    .CLK_6M(clk), .W_1EF_RST(rst_n), .I_START(start), .I_CMPBLKn(blank_n),
    .I_DL_VALID(valid), .I_DL_DATA(data), .O_DL_READY(r1), .O_CNF_A(a1),
    .O_CNF_D(d1), .O_CNF_EN(en1), .O_WE2(w2_1), .O_WE3(w3_1), .O_BUSY(b1),
    .O_DONE(dn1), .O_ERR(e1)
  );

  wire [22:0] outs0 = {r0, a0, d0, en0, w2_0, w3_0, b0, dn0, e0};
  wire [22:0] outs1 = {r1, a1, d1, en1, w2_1, w3_1, b1, dn1, e1};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every u0 strobe must carry the next expected address and byte
  always @(negedge clk)
    if (mon_en && (w2_0 || w3_0)) begin
      check("strobe_in_range", 32'(exp_idx < PAL_BYTES), 1);
      if (exp_idx < PAL_BYTES) begin
        check("we2_sel", w2_0, 32'(exp_idx < 256));
        check("we3_sel", w3_0, 32'(exp_idx >= 256));
        check("cnf_a", a0, 32'(exp_idx % 256));
        check("cnf_d", d0, exp_data[exp_idx]);
      end
      exp_idx++;
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    valid = 1'b1;
    data  = b;
    while (!r0 && t < 1000) begin
      tick();
      t++;
    end
    check("ready_wait", 32'(t < 1000), 1);
    if (t < 1000) tick();
    valid = 1'b0;
  endtask

  task automatic run_stream(input bit rnd, input logic [7:0] tr_add, input int n);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < PAL_BYTES; i++) begin
      exp_data[i] = rnd ? 8'($urandom) : 8'(i);
      s += exp_data[i];
    end
    exp_idx = 0;
    mon_en  = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (rnd) while ($urandom_range(0, 9) > 2) tick();
      send_byte(exp_data[i]);
    end
    if (n == PAL_BYTES) begin
      send_byte(8'(tr_add - s));
      tick();
      check("strobe_count", 32'(exp_idx), PAL_BYTES);
      check("done_err_u0", {dn0, e0, b0, r0}, {1'b1, tr_add != 8'h00, 2'b00});
      check("done_err_u1", {dn1, e1}, {1'b1, tr_add != 8'h00});
      mon_en = 1'b0;
    end
  endtask

  initial begin
    #2;
    check("rst_u0", outs0, 0);
    check("rst_u1", outs1, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    valid = 1'b1;
    tick();
    check("idle_ignore", {r0, en0, b0, dn0}, 0);
    valid = 1'b0;
    // full stream, good checksum
    pulse_start();
    check("start_busy", {en0, b0, r0, dn0}, 4'b1110);
    run_stream(1'b0, 8'h00, PAL_BYTES);
    check("hold_a", a0, 8'hff);
    check("hold_d", d0, 8'hff);
    // bad trailer
    pulse_start();
    check("done_cleared", {dn0, e0}, 0);
    run_stream(1'b0, 8'h01, PAL_BYTES);
    // blank gating on u1, ungated write on u0
    blank_n = 1'b1;
    pulse_start();
    valid = 1'b1;
    data  = 8'h5a;
    tick();
    valid   = 1'b0;
    we_cnt  = 0;
    rdy_cnt = 0;
    repeat (20) begin
      we_cnt  += int'(w2_1 | w3_1);
      rdy_cnt += int'(r1);
      tick();
    end
    check("blk_no_we", 32'(we_cnt), 0);
    check("blk_no_rdy", 32'(rdy_cnt), 0);
    check("wib0_wrote", {a0, d0, r0}, {8'h00, 8'h5a, 1'b1});
    blank_n = 1'b0;
    tick();
    check("blk_we2", {w2_1, w3_1, a1, d1}, {2'b10, 8'h00, 8'h5a});
    tick();
    check("blk_we2_one", {w2_1, w3_1, r1}, 3'b001);
    // restart mid-load while a write is pending
    pulse_start();
    run_stream(1'b0, 8'h00, 300);
    mon_en = 1'b0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check("restart_no_we", {w2_0, w3_0}, 0);
    check("restart_rdy", r0, 1);
    start = 1'b1;
    valid = 1'b1;
    data  = 8'hee;
    tick();
    start = 1'b0;
    valid = 1'b0;
    check("start_drops_byte", r0, 1);
    run_stream(1'b0, 8'h00, PAL_BYTES);
    // asynchronous reset mid-load
    pulse_start();
    run_stream(1'b0, 8'h00, 100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_u0", outs0, 0);
    check("arst_u1", outs1, 0);
    mon_en = 1'b0;
    tick();
    rst_n   = 1'b1;
    valid   = 1'b1;
    data    = 8'h33;
    we_cnt  = 0;
    rdy_cnt = 0;
    repeat (5) begin
      tick();
      we_cnt  += int'(w2_0 | w3_0 | w2_1 | w3_1);
      rdy_cnt += int'(r0 | r1 | en0);
    end
    valid = 1'b0;
    check("post_rst_we", 32'(we_cnt), 0);
    check("post_rst_rdy", 32'(rdy_cnt), 0);
    // random bytes with sparse valid
    pulse_start();
    run_stream(1'b1, 8'h00, PAL_BYTES);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dkongjr_pal_loader.md
Name: dkongjr_pal_loader

Overview:
- Writer side of the colour-palette configuration interface.
- Accepts a byte stream from the download path and sequences it into the two palette RAMs (2E and 2F) over the CNF_A / CNF_D / CNF_EN / WE2 / WE3 bus consumed by the colour-palette block.
- Verifies the stream with a trailer checksum and reports busy, done and error status to the top level.

Parameters:
- PAL_DEPTH, 256, entries per palette RAM. Address width is fixed at 8, so this must be 256.
- WRITE_IN_BLANK, 1, 1 = write strobes issue only while I_CMPBLKn=0; 0 = strobes issue in any cycle.

Ports:
- CLK_6M  in  1  pixel clock; all logic on rising edge.
- W_1EF_RST  in  1  reset, asynchronous, active-low.
- I_START  in  1  start or restart a load; sampled every cycle.
- I_CMPBLKn  in  1  composite blank, active-low; 0 = blanking.
- I_DL_VALID  in  1  download byte valid.
- I_DL_DATA  in  8  download byte.
- O_DL_READY  out  1  loader can accept a byte.
- O_CNF_A  out  8  palette RAM address.
- O_CNF_D  out  8  palette RAM write data.
- O_CNF_EN  out  1  palette address mux selects the config bus.
- O_WE2  out  1  one-cycle write strobe, palette 2E (G/B nibble).
- O_WE3  out  1  one-cycle write strobe, palette 2F (R/G nibble).
- O_BUSY  out  1  load in progress.
- O_DONE  out  1  load finished; held until the next start.
- O_ERR  out  1  checksum mismatch; valid while O_DONE=1.

Behaviour:
- Reset (W_1EF_RST=0, asynchronous):
  - State = IDLE; addr = 0; checksum = 0; hold register empty.
  - All outputs 0, including O_CNF_A and O_CNF_D.
- States: IDLE, LOAD2E, LOAD2F, CHECK, DONE.
- I_START=1 in any state:
  - Next state = LOAD2E; addr = 0; checksum = 0; hold register emptied; O_DONE = 0; O_ERR = 0.
  - Start has priority over a same-cycle accept or write: that byte is discarded and no strobe issues.
- O_CNF_EN = 1 in LOAD2E, LOAD2F and CHECK; 0 otherwise.
- O_BUSY equals O_CNF_EN.
- O_DL_READY = (state is LOAD2E, LOAD2F or CHECK) AND hold register empty.
- Accept: I_DL_VALID & O_DL_READY at a rising edge.
  - Byte loads into the hold register.
  - checksum <= checksum + byte, modulo 256.
- Write, in LOAD2E / LOAD2F only:
  - Occurs in a cycle where the hold register is full and (WRITE_IN_BLANK=0 or I_CMPBLKn=0).
  - Registered outputs for exactly one cycle: O_CNF_A = addr, O_CNF_D = held byte, and O_WE2 (LOAD2E) or O_WE3 (LOAD2F) = 1.
  - At the same edge: hold register emptied, addr increments.
- Latency:
  - Accept at edge N produces the strobe at edge N+1 at the earliest.
  - Earliest next accept is edge N+2, so peak throughput is 1 byte per 2 cycles.
- Outside a write cycle:
  - O_WE2 and O_WE3 = 0.
  - O_CNF_A and O_CNF_D hold their last written values.
- Address wrap:
  - Write at addr 255 in LOAD2E: addr -> 0, state -> LOAD2F.
  - Write at addr 255 in LOAD2F: state -> CHECK.
- CHECK:
  - Accepts exactly one trailer byte; it is added to the checksum and is never written to a palette RAM.
  - Next cycle: state -> DONE; O_ERR = (checksum of all 513 bytes != 0).
- DONE: O_DONE = 1; O_CNF_EN = 0; inputs ignored except I_START.
- Blank gating with WRITE_IN_BLANK=1: a held byte waits indefinitely while I_CMPBLKn=1 and O_DL_READY stays 0 during the wait.
- I_DL_VALID in IDLE or DONE is ignored and no accept occurs.
- Reset mid-load: immediate return to IDLE. The palette RAM keeps whatever was already written; no rollback.

Decomposition:
- Shared package dkongjr_pal_pkg:
  - state encoding: IDLE=0, LOAD2E=1, LOAD2F=2, CHECK=3, DONE=4;
  - PAL_AW=8;
  - PAL_BYTES=512.
- One natural sub-module, dkongjr_pal_hold: one-entry skid/hold register with valid flag and blank-gated drain. Sequencer, address counter and checksum stay in the top module.

Test Plan:
- Reset, then I_START, then 512 bytes b[i]=i[7:0] with valid held high, trailer 0x00, WRITE_IN_BLANK=0.
  - 256 O_WE2 pulses with CNF_A=D=0..255, then 256 O_WE3 pulses with the same values.
  - O_DONE=1 and O_ERR=0, because the sum 2*32640 mod 256 = 0.
- Same stream with trailer 0x01 -> O_DONE=1, O_ERR=1.
- WRITE_IN_BLANK=1 with I_CMPBLKn=1 for 20 cycles:
  - one byte accepted, no WE pulse, O_DL_READY=0;
  - I_CMPBLKn drops -> single WE2 pulse at addr 0 on the next edge.
- I_START at byte 300 of a load:
  - no strobe in that cycle;
  - next write is WE2 at addr 0 and the checksum restarts.
- W_1EF_RST low at byte 100:
  - all outputs 0 asynchronously, state IDLE;
  - after release, I_DL_VALID=1 gives O_DL_READY=0 and no strobes.
- Valid toggled randomly at 30 % duty, full 513-byte stream:
  - exactly 512 strobes, addresses strictly sequential, no lost or duplicated bytes (scoreboard comparison).
